// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the core sequencer
// (port C) and the serial program loader (port L). The winner's request is
// latched at grant, the RAM strobe is held for WAIT_CYC cycles, then a
// one-cycle ack is returned together with the read data. Port C can lock the
// RAM so that a multi-access sequence is not interleaved with loader traffic.
module ram_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              reg_clear_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic              c_lock,
    output logic              c_ack,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_r,
    output logic              ram_w,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        gnt,
    output logic              busy
);

    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_l_q, last_l_d;     // 1: loader won the previous grant
    logic              lock_own_q, lock_own_d; // core holds the RAM
    logic [1:0]        gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;             // latched direction of the access
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              c_ack_q, c_ack_d;
    logic              l_ack_q, l_ack_d;

    logic              elig_c, elig_l, pick_l, sel_we;

    // Next-state logic: arbitration in IDLE, strobe timing in ACCESS, ack in RESP
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_l_d   = last_l_q;
        lock_own_d = lock_own_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        we_d       = we_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        c_ack_d    = 1'b0;
        l_ack_d    = 1'b0;
        elig_c     = c_req;
        elig_l     = l_req & ~lock_own_q;
        pick_l     = elig_l & (~elig_c | ~last_l_q);
        sel_we     = pick_l ? l_we : c_we;

        case (state_q)
            S_IDLE: begin
                if (!c_lock) begin
                    lock_own_d = 1'b0;
                end
                if (elig_c || elig_l) begin
                    if (pick_l) begin
                        gnt_d   = 2'b10;
                        addr_d  = l_addr;
                        wdata_d = l_wdata;
                    end else begin
                        gnt_d      = 2'b01;
                        addr_d     = c_addr;
                        wdata_d    = c_wdata;
                        lock_own_d = c_lock;
                    end
                    we_d     = sel_we;
                    rd_d     = ~sel_we;
                    wr_d     = sel_we;
                    last_l_d = pick_l;
                    cnt_d    = CNT_W'(WAIT_CYC - 1);
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!we_q) begin
                        rdata_d = ram_rdata;
                    end
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    c_ack_d = gnt_q[0];
                    l_ack_d = gnt_q[1];
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any access in flight without an ack
    always_ff @(posedge clk) begin
        if (!reg_clear_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_l_q   <= 1'b1;
            lock_own_q <= 1'b0;
            gnt_q      <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            we_q       <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            c_ack_q    <= 1'b0;
            l_ack_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_l_q   <= last_l_d;
            lock_own_q <= lock_own_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            c_ack_q    <= c_ack_d;
            l_ack_q    <= l_ack_d;
        end
    end

    assign c_ack     = c_ack_q;
    assign l_ack     = l_ack_q;
    assign rdata     = rdata_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_r     = rd_q;
    assign ram_w     = wr_q;
    assign gnt       = gnt_q;
    assign busy      = (state_q != S_IDLE);

endmodule
